// File: rtl/gen_seq_pkg.sv
// Shared types and constants for the generator sequencer: FSM state
// encoding and the host-visible configuration field map.
package gen_seq_pkg;

    localparam int FIELD_W = 4;

    // Host field indices; index 15 is unused and writes to it are dropped.
    localparam logic [FIELD_W-1:0] FIELD_ITER   = 4'd0;
    localparam logic [FIELD_W-1:0] FIELD_SHIFT  = 4'd1;
    localparam logic [FIELD_W-1:0] FIELD_PER    = 4'd2;
    localparam logic [FIELD_W-1:0] FIELD_INCR   = 4'd3;
    localparam logic [FIELD_W-1:0] FIELD_ITER2  = 4'd4;
    localparam logic [FIELD_W-1:0] FIELD_SHIFT2 = 4'd5;
    localparam logic [FIELD_W-1:0] FIELD_PER2   = 4'd6;
    localparam logic [FIELD_W-1:0] FIELD_INCR2  = 4'd7;
    localparam logic [FIELD_W-1:0] FIELD_ITER3  = 4'd8;
    localparam logic [FIELD_W-1:0] FIELD_SHIFT3 = 4'd9;
    localparam logic [FIELD_W-1:0] FIELD_PER3   = 4'd10;
    localparam logic [FIELD_W-1:0] FIELD_INCR3  = 4'd11;
    localparam logic [FIELD_W-1:0] FIELD_DUTY   = 4'd12;
    localparam logic [FIELD_W-1:0] FIELD_START  = 4'd13;
    localparam logic [FIELD_W-1:0] FIELD_DELAY  = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_ARM    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

endpackage

// File: rtl/gen_seq_cfg_bank.sv
// Configuration bank: NUM_CFG slots of 15 generator fields, one host write
// port and one full-slot combinational read port.
module gen_seq_cfg_bank
    import gen_seq_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int DELAY_W  = 7,
    parameter int NUM_CFG  = 4,
    localparam int SLOT_W  = $clog2(NUM_CFG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [SLOT_W-1:0]   wr_slot_i,
    input  logic [FIELD_W-1:0]  wr_field_i,
    input  logic [31:0]         wr_data_i,
    input  logic [SLOT_W-1:0]   rd_slot_i,
    output logic [31:0]         rd_iter_o,
    output logic [31:0]         rd_iter2_o,
    output logic [31:0]         rd_iter3_o,
    output logic [31:0]         rd_shift_o,
    output logic [31:0]         rd_shift2_o,
    output logic [31:0]         rd_shift3_o,
    output logic [PERIOD_W-1:0] rd_per_o,
    output logic [PERIOD_W-1:0] rd_per2_o,
    output logic [PERIOD_W-1:0] rd_per3_o,
    output logic [31:0]         rd_incr_o,
    output logic [31:0]         rd_incr2_o,
    output logic [31:0]         rd_incr3_o,
    output logic [PERIOD_W-1:0] rd_duty_o,
    output logic [31:0]         rd_start_o,
    output logic [DELAY_W-1:0]  rd_delay_o
);

    // Storage is grouped by width so narrow fields only keep their LSBs.
    localparam int W_ITER = 0, W_ITER2 = 1, W_ITER3 = 2;
    localparam int W_SHIFT = 3, W_SHIFT2 = 4, W_SHIFT3 = 5;
    localparam int W_INCR = 6, W_INCR2 = 7, W_INCR3 = 8, W_START = 9;
    localparam int NUM_WIDE = 10;
    localparam int P_PER = 0, P_PER2 = 1, P_PER3 = 2, P_DUTY = 3;
    localparam int NUM_PER = 4;

    logic [31:0]         wide_q  [NUM_CFG][NUM_WIDE];
    logic [31:0]         wide_d  [NUM_CFG][NUM_WIDE];
    logic [PERIOD_W-1:0] per_q   [NUM_CFG][NUM_PER];
    logic [PERIOD_W-1:0] per_d   [NUM_CFG][NUM_PER];
    logic [DELAY_W-1:0]  delay_q [NUM_CFG];
    logic [DELAY_W-1:0]  delay_d [NUM_CFG];

    // Decode the host field index into the matching storage cell.
    always_comb begin
        wide_d  = wide_q;
        per_d   = per_q;
        delay_d = delay_q;
        if (we_i) begin
            case (wr_field_i)
                FIELD_ITER:   wide_d[wr_slot_i][W_ITER]   = wr_data_i;
                FIELD_SHIFT:  wide_d[wr_slot_i][W_SHIFT]  = wr_data_i;
                FIELD_PER:    per_d[wr_slot_i][P_PER]     = wr_data_i[PERIOD_W-1:0];
                FIELD_INCR:   wide_d[wr_slot_i][W_INCR]   = wr_data_i;
                FIELD_ITER2:  wide_d[wr_slot_i][W_ITER2]  = wr_data_i;
                FIELD_SHIFT2: wide_d[wr_slot_i][W_SHIFT2] = wr_data_i;
                FIELD_PER2:   per_d[wr_slot_i][P_PER2]    = wr_data_i[PERIOD_W-1:0];
                FIELD_INCR2:  wide_d[wr_slot_i][W_INCR2]  = wr_data_i;
                FIELD_ITER3:  wide_d[wr_slot_i][W_ITER3]  = wr_data_i;
                FIELD_SHIFT3: wide_d[wr_slot_i][W_SHIFT3] = wr_data_i;
                FIELD_PER3:   per_d[wr_slot_i][P_PER3]    = wr_data_i[PERIOD_W-1:0];
                FIELD_INCR3:  wide_d[wr_slot_i][W_INCR3]  = wr_data_i;
                FIELD_DUTY:   per_d[wr_slot_i][P_DUTY]    = wr_data_i[PERIOD_W-1:0];
                FIELD_START:  wide_d[wr_slot_i][W_START]  = wr_data_i;
                FIELD_DELAY:  delay_d[wr_slot_i]          = wr_data_i[DELAY_W-1:0];
                default: ;
            endcase
        end
    end

    // Bank registers; reset clears every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_CFG; s++) begin
                for (int w = 0; w < NUM_WIDE; w++) wide_q[s][w] <= '0;
                for (int p = 0; p < NUM_PER; p++) per_q[s][p] <= '0;
                delay_q[s] <= '0;
            end
        end else begin
            wide_q  <= wide_d;
            per_q   <= per_d;
            delay_q <= delay_d;
        end
    end

    assign rd_iter_o   = wide_q[rd_slot_i][W_ITER];
    assign rd_iter2_o  = wide_q[rd_slot_i][W_ITER2];
    assign rd_iter3_o  = wide_q[rd_slot_i][W_ITER3];
    assign rd_shift_o  = wide_q[rd_slot_i][W_SHIFT];
    assign rd_shift2_o = wide_q[rd_slot_i][W_SHIFT2];
    assign rd_shift3_o = wide_q[rd_slot_i][W_SHIFT3];
    assign rd_incr_o   = wide_q[rd_slot_i][W_INCR];
    assign rd_incr2_o  = wide_q[rd_slot_i][W_INCR2];
    assign rd_incr3_o  = wide_q[rd_slot_i][W_INCR3];
    assign rd_start_o  = wide_q[rd_slot_i][W_START];
    assign rd_per_o    = per_q[rd_slot_i][P_PER];
    assign rd_per2_o   = per_q[rd_slot_i][P_PER2];
    assign rd_per3_o   = per_q[rd_slot_i][P_PER3];
    assign rd_duty_o   = per_q[rd_slot_i][P_DUTY];
    assign rd_delay_o  = delay_q[rd_slot_i];

endmodule

// File: rtl/gen_sequencer.sv
// Sequencer for one address generator: runs slots 0..len-1 back to back,
// repeating the whole sequence rep+1 times, one run pulse per slot.
//
// Handshake with the generator: gen_run_o is a single-cycle request; the
// generator answers with the level gen_done_i. Done is ignored in the cycle
// after the run pulse (ARM) so a done level left over from the previous run
// cannot complete the new one. abort_i overrides everything.
module gen_sequencer
    import gen_seq_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int DELAY_W  = 7,
    parameter int NUM_CFG  = 4,
    localparam int SLOT_W  = $clog2(NUM_CFG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we_i,
    input  logic [SLOT_W-1:0]   cfg_slot_i,
    input  logic [FIELD_W-1:0]  cfg_field_i,
    input  logic [31:0]         cfg_wdata_i,
    input  logic                go_i,
    input  logic                abort_i,
    input  logic [SLOT_W:0]     seq_len_i,
    input  logic [15:0]         rep_cnt_i,
    input  logic                stall_i,
    input  logic                gen_done_i,
    output logic                gen_run_o,
    output logic                gen_running_o,
    output logic [31:0]         gen_iter_o,
    output logic [31:0]         gen_iter2_o,
    output logic [31:0]         gen_iter3_o,
    output logic [31:0]         gen_shift_o,
    output logic [31:0]         gen_shift2_o,
    output logic [31:0]         gen_shift3_o,
    output logic [PERIOD_W-1:0] gen_per_o,
    output logic [PERIOD_W-1:0] gen_per2_o,
    output logic [PERIOD_W-1:0] gen_per3_o,
    output logic [31:0]         gen_incr_o,
    output logic [31:0]         gen_incr2_o,
    output logic [31:0]         gen_incr3_o,
    output logic [PERIOD_W-1:0] gen_duty_o,
    output logic [31:0]         gen_start_o,
    output logic [DELAY_W-1:0]  gen_delay_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [SLOT_W-1:0]   cur_slot_o
);

    localparam logic [SLOT_W:0] NUM_CFG_L = (SLOT_W+1)'(NUM_CFG);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [15:0]         pass_q, pass_d;
    logic [SLOT_W:0]     len_q, len_d;
    logic [15:0]         rep_q, rep_d;
    logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic                load_en;
    logic [SLOT_W:0]     eff_len;
    logic                more_slots;

    logic [31:0]         rd_iter, rd_iter2, rd_iter3, rd_shift, rd_shift2, rd_shift3;
    logic [31:0]         rd_incr, rd_incr2, rd_incr3, rd_start;
    logic [PERIOD_W-1:0] rd_per, rd_per2, rd_per3, rd_duty;
    logic [DELAY_W-1:0]  rd_delay;

    logic [31:0]         iter_q, iter2_q, iter3_q, shift_q, shift2_q, shift3_q;
    logic [31:0]         iter_d, iter2_d, iter3_d, shift_d, shift2_d, shift3_d;
    logic [31:0]         incr_q, incr2_q, incr3_q, start_q;
    logic [31:0]         incr_d, incr2_d, incr3_d, start_d;
    logic [PERIOD_W-1:0] per_q, per2_q, per3_q, duty_q;
    logic [PERIOD_W-1:0] per_d, per2_d, per3_d, duty_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;

    gen_seq_cfg_bank #(
        .PERIOD_W (PERIOD_W),
        .DELAY_W  (DELAY_W),
        .NUM_CFG  (NUM_CFG)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .we_i       (cfg_we_i),
        .wr_slot_i  (cfg_slot_i),
        .wr_field_i (cfg_field_i),
        .wr_data_i  (cfg_wdata_i),
        .rd_slot_i  (slot_q),
        .rd_iter_o  (rd_iter),
        .rd_iter2_o (rd_iter2),
        .rd_iter3_o (rd_iter3),
        .rd_shift_o (rd_shift),
        .rd_shift2_o(rd_shift2),
        .rd_shift3_o(rd_shift3),
        .rd_per_o   (rd_per),
        .rd_per2_o  (rd_per2),
        .rd_per3_o  (rd_per3),
        .rd_incr_o  (rd_incr),
        .rd_incr2_o (rd_incr2),
        .rd_incr3_o (rd_incr3),
        .rd_duty_o  (rd_duty),
        .rd_start_o (rd_start),
        .rd_delay_o (rd_delay)
    );

    assign eff_len    = (seq_len_i > NUM_CFG_L) ? NUM_CFG_L : seq_len_i;
    assign more_slots = (({1'b0, slot_q} + (SLOT_W+1)'(1)) < len_q);

    // Next-state logic for the sequencing FSM and its counters.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        pass_d     = pass_q;
        len_d      = len_q;
        rep_d      = rep_q;
        cur_slot_d = cur_slot_q;
        run_d      = 1'b0;
        done_d     = 1'b0;
        load_en    = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_i) begin
                        if (eff_len != '0) begin
                            state_d = ST_LOAD;
                            len_d   = eff_len;
                            rep_d   = rep_cnt_i;
                            slot_d  = '0;
                            pass_d  = '0;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_LOAD: begin
                    load_en    = 1'b1;
                    cur_slot_d = slot_q;
                    run_d      = 1'b1;
                    state_d    = ST_PULSE;
                end
                ST_PULSE: state_d = ST_ARM;
                ST_ARM:   state_d = ST_WAIT;
                ST_WAIT: begin
                    if (gen_done_i) begin
                        if (more_slots) begin
                            slot_d  = slot_q + SLOT_W'(1);
                            state_d = ST_LOAD;
                        end else if (pass_q < rep_q) begin
                            pass_d  = pass_q + 16'd1;
                            slot_d  = '0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Generator configuration registers, refreshed only on LOAD.
    always_comb begin
        iter_d   = load_en ? rd_iter   : iter_q;
        iter2_d  = load_en ? rd_iter2  : iter2_q;
        iter3_d  = load_en ? rd_iter3  : iter3_q;
        shift_d  = load_en ? rd_shift  : shift_q;
        shift2_d = load_en ? rd_shift2 : shift2_q;
        shift3_d = load_en ? rd_shift3 : shift3_q;
        per_d    = load_en ? rd_per    : per_q;
        per2_d   = load_en ? rd_per2   : per2_q;
        per3_d   = load_en ? rd_per3   : per3_q;
        incr_d   = load_en ? rd_incr   : incr_q;
        incr2_d  = load_en ? rd_incr2  : incr2_q;
        incr3_d  = load_en ? rd_incr3  : incr3_q;
        duty_d   = load_en ? rd_duty   : duty_q;
        start_d  = load_en ? rd_start  : start_q;
        delay_d  = load_en ? rd_delay  : delay_q;
    end

    // FSM state, counters and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            pass_q     <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            cur_slot_q <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            iter_q     <= '0; iter2_q  <= '0; iter3_q  <= '0;
            shift_q    <= '0; shift2_q <= '0; shift3_q <= '0;
            per_q      <= '0; per2_q   <= '0; per3_q   <= '0;
            incr_q     <= '0; incr2_q  <= '0; incr3_q  <= '0;
            duty_q     <= '0; start_q  <= '0; delay_q  <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            pass_q     <= pass_d;
            len_q      <= len_d;
            rep_q      <= rep_d;
            cur_slot_q <= cur_slot_d;
            run_q      <= run_d;
            done_q     <= done_d;
            iter_q     <= iter_d;  iter2_q  <= iter2_d;  iter3_q  <= iter3_d;
            shift_q    <= shift_d; shift2_q <= shift2_d; shift3_q <= shift3_d;
            per_q      <= per_d;   per2_q   <= per2_d;   per3_q   <= per3_d;
            incr_q     <= incr_d;  incr2_q  <= incr2_d;  incr3_q  <= incr3_d;
            duty_q     <= duty_d;  start_q  <= start_d;  delay_q  <= delay_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign gen_running_o = ((state_q == ST_PULSE) || (state_q == ST_ARM) ||
                            (state_q == ST_WAIT)) && !stall_i;
    assign gen_run_o     = run_q;
    assign done_o        = done_q;
    assign cur_slot_o    = cur_slot_q;
    assign gen_iter_o    = iter_q;
    assign gen_iter2_o   = iter2_q;
    assign gen_iter3_o   = iter3_q;
    assign gen_shift_o   = shift_q;
    assign gen_shift2_o  = shift2_q;
    assign gen_shift3_o  = shift3_q;
    assign gen_per_o     = per_q;
    assign gen_per2_o    = per2_q;
    assign gen_per3_o    = per3_q;
    assign gen_incr_o    = incr_q;
    assign gen_incr2_o   = incr2_q;
    assign gen_incr3_o   = incr3_q;
    assign gen_duty_o    = duty_q;
    assign gen_start_o   = start_q;
    assign gen_delay_o   = delay_q;

endmodule

// File: tb/tb_gen_sequencer.sv
// Bench for gen_sequencer: directed sequences with literal timing checks,
// then randomized traffic compared every cycle against a timeline model.
module tb_gen_sequencer;
    import gen_seq_pkg::*;

    localparam int PERIOD_W = 16;
    localparam int DELAY_W  = 7;
    localparam int NUM_CFG  = 4;
    localparam int SLOT_W   = 2;
    localparam logic [31:0] PMASK = 32'h0000_FFFF;
    localparam logic [31:0] DMASK = 32'h0000_007F;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_we_i = 1'b0;
    logic [SLOT_W-1:0] cfg_slot_i = '0;
    logic [3:0] cfg_field_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic go_i = 1'b0, abort_i = 1'b0, stall_i = 1'b0, gen_done_i = 1'b0;
    logic [SLOT_W:0] seq_len_i = '0;
    logic [15:0] rep_cnt_i = '0;

    logic gen_run_o, gen_running_o, busy_o, done_o;
    logic [31:0] gen_iter_o, gen_iter2_o, gen_iter3_o, gen_shift_o, gen_shift2_o, gen_shift3_o;
    logic [31:0] gen_incr_o, gen_incr2_o, gen_incr3_o, gen_start_o;
    logic [PERIOD_W-1:0] gen_per_o, gen_per2_o, gen_per3_o, gen_duty_o;
    logic [DELAY_W-1:0] gen_delay_o;
    logic [SLOT_W-1:0] cur_slot_o;

    always #5 clk = ~clk;

    gen_sequencer #(.PERIOD_W(PERIOD_W), .DELAY_W(DELAY_W), .NUM_CFG(NUM_CFG)) dut (
        .clk(clk), .rst(rst), .cfg_we_i(cfg_we_i), .cfg_slot_i(cfg_slot_i),
        .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i), .go_i(go_i),
        .abort_i(abort_i), .seq_len_i(seq_len_i), .rep_cnt_i(rep_cnt_i),
        .stall_i(stall_i), .gen_done_i(gen_done_i), .gen_run_o(gen_run_o),
        .gen_running_o(gen_running_o), .gen_iter_o(gen_iter_o), .gen_iter2_o(gen_iter2_o),
        .gen_iter3_o(gen_iter3_o), .gen_shift_o(gen_shift_o), .gen_shift2_o(gen_shift2_o),
        .gen_shift3_o(gen_shift3_o), .gen_per_o(gen_per_o), .gen_per2_o(gen_per2_o),
        .gen_per3_o(gen_per3_o), .gen_incr_o(gen_incr_o), .gen_incr2_o(gen_incr2_o),
        .gen_incr3_o(gen_incr3_o), .gen_duty_o(gen_duty_o), .gen_start_o(gen_start_o),
        .gen_delay_o(gen_delay_o), .busy_o(busy_o), .done_o(done_o), .cur_slot_o(cur_slot_o)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] got[$], input logic [31:0] exp_q[$]);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            chk(name, got[k], exp_q[k]);
    endtask

    // ---------------- behavioural timeline model ----------------
    // Edge-indexed: a go seen at edge n loads slot 0 at edge n+1 (run pulse
    // visible after it); done is honoured from three edges after a load;
    // a finishing sequence drops busy and shows done one edge after the
    // last done (or immediately after go for an empty sequence).
    bit model_valid = 0;
    int n = 0;
    bit act = 0;
    int load_at = -1, done_ok_from = 0, finish_at = -1;
    int m_slot = 0, m_pass = 0, m_len = 0, m_rep = 0, eff = 0;
    logic [31:0] m_bank [NUM_CFG][15];
    logic [31:0] e_f [15];
    logic e_run = 0, e_done = 0, e_busy = 0, e_run_st = 0;
    logic [31:0] e_cur = '0;

    always @(posedge clk) begin
        n++;
        e_run = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            model_valid = 1;
            act = 0; load_at = -1; finish_at = -1; done_ok_from = 0;
            for (int s = 0; s < NUM_CFG; s++)
                for (int f = 0; f < 15; f++) m_bank[s][f] = '0;
            for (int f = 0; f < 15; f++) e_f[f] = '0;
            e_cur = '0;
        end else begin
            if (abort_i) begin
                act = 0; load_at = -1; finish_at = -1;
            end else if (!act) begin
                if (go_i) begin
                    eff = (int'(seq_len_i) > NUM_CFG) ? NUM_CFG : int'(seq_len_i);
                    act = 1;
                    if (eff == 0) begin
                        finish_at = n + 1;
                    end else begin
                        m_len = eff; m_rep = int'(rep_cnt_i); m_slot = 0; m_pass = 0;
                        load_at = n + 1; done_ok_from = n + 4;
                    end
                end
            end else if (n == finish_at) begin
                act = 0; finish_at = -1; e_done = 1'b1;
            end else if (n == load_at) begin
                for (int f = 0; f < 15; f++) e_f[f] = m_bank[m_slot][f];
                e_cur = 32'(m_slot);
                e_run = 1'b1;
            end else if (finish_at < 0 && n >= done_ok_from && gen_done_i) begin
                if (m_slot < m_len - 1) begin
                    m_slot++; load_at = n + 1; done_ok_from = n + 4;
                end else if (m_pass < m_rep) begin
                    m_pass++; m_slot = 0; load_at = n + 1; done_ok_from = n + 4;
                end else begin
                    finish_at = n + 1;
                end
            end
            if (cfg_we_i && cfg_field_i != 4'd15)
                m_bank[cfg_slot_i][cfg_field_i] = cfg_wdata_i;
        end
        e_busy = act;
        e_run_st = act && finish_at < 0 && load_at >= 0 && n >= load_at;
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("gen_run", 32'(gen_run_o), 32'(e_run));
            chk("done", 32'(done_o), 32'(e_done));
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("gen_running", 32'(gen_running_o), 32'(e_run_st & ~stall_i));
            chk("cur_slot", 32'(cur_slot_o), e_cur);
            chk("iter", gen_iter_o, e_f[FIELD_ITER]);
            chk("iter2", gen_iter2_o, e_f[FIELD_ITER2]);
            chk("iter3", gen_iter3_o, e_f[FIELD_ITER3]);
            chk("shift", gen_shift_o, e_f[FIELD_SHIFT]);
            chk("shift2", gen_shift2_o, e_f[FIELD_SHIFT2]);
            chk("shift3", gen_shift3_o, e_f[FIELD_SHIFT3]);
            chk("per", 32'(gen_per_o), e_f[FIELD_PER] & PMASK);
            chk("per2", 32'(gen_per2_o), e_f[FIELD_PER2] & PMASK);
            chk("per3", 32'(gen_per3_o), e_f[FIELD_PER3] & PMASK);
            chk("incr", gen_incr_o, e_f[FIELD_INCR]);
            chk("incr2", gen_incr2_o, e_f[FIELD_INCR2]);
            chk("incr3", gen_incr3_o, e_f[FIELD_INCR3]);
            chk("duty", 32'(gen_duty_o), e_f[FIELD_DUTY] & PMASK);
            chk("start", gen_start_o, e_f[FIELD_START]);
            chk("delay", 32'(gen_delay_o), e_f[FIELD_DELAY] & DMASK);
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] runs_q[$], slots_q[$], starts_q[$], dones_q[$];

    task automatic wr(input int slot, input logic [3:0] field, input logic [31:0] data);
        @(posedge clk); #2;
        cfg_we_i = 1'b1; cfg_slot_i = SLOT_W'(slot); cfg_field_i = field; cfg_wdata_i = data;
        @(posedge clk); #2;
        cfg_we_i = 1'b0;
    endtask

    // Pulse go, then record run/done offsets (edge index after the go edge).
    // dmode 0: done low; 1: done held high; 2: done pulsed dly after each run.
    task automatic run_seq(input int len, input int rep, input int dmode, input int dly,
                           input int abort_at, input int wr_at, input int ncyc);
        int last_run;
        runs_q.delete(); slots_q.delete(); starts_q.delete(); dones_q.delete();
        last_run = -100;
        @(posedge clk); #2;
        seq_len_i = (SLOT_W+1)'(len); rep_cnt_i = 16'(rep); go_i = 1'b1;
        gen_done_i = (dmode == 1);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            go_i = 1'b0; abort_i = 1'b0; cfg_we_i = 1'b0;
            if (gen_run_o) begin
                runs_q.push_back(32'(i)); slots_q.push_back(32'(cur_slot_o));
                starts_q.push_back(gen_start_o); last_run = i;
            end
            if (done_o) dones_q.push_back(32'(i));
            if (dmode == 2) gen_done_i = (i == last_run + dly);
            if (i == abort_at) abort_i = 1'b1;
            if (i == wr_at) begin
                cfg_we_i = 1'b1; cfg_slot_i = 2'd2; cfg_field_i = FIELD_START; cfg_wdata_i = 32'h200;
            end
        end
        gen_done_i = 1'b0; abort_i = 1'b0; cfg_we_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_q[$];
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_start", gen_start_o, 32'd0);
        chk("rst_cur_slot", 32'(cur_slot_o), 32'd0);

        // Single slot, done returned 10 cycles after the run pulse.
        wr(0, FIELD_ITER, 32'd4);
        wr(0, FIELD_PER, 32'd2);
        wr(0, FIELD_INCR, 32'd1);
        wr(0, FIELD_START, 32'h100);
        run_seq(1, 0, 2, 10, -1, -1, 16);
        exp_q = '{32'd1};              chk_q("t1_runs", runs_q, exp_q);
        exp_q = '{32'h100};            chk_q("t1_start", starts_q, exp_q);
        exp_q = '{32'd13};             chk_q("t1_done", dones_q, exp_q);
        chk("t1_busy_end", 32'(busy_o), 32'd0);

        // Three slots, two passes, slot 2 rewritten while slot 1 runs.
        wr(1, FIELD_START, 32'h110);
        wr(2, FIELD_START, 32'h120);
        run_seq(3, 1, 2, 3, -1, 8, 36);
        exp_q = '{32'd1, 32'd6, 32'd11, 32'd16, 32'd21, 32'd26};  chk_q("t2_runs", runs_q, exp_q);
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};      chk_q("t2_slots", slots_q, exp_q);
        exp_q = '{32'h100, 32'h110, 32'h200, 32'h100, 32'h110, 32'h200};
        chk_q("t2_start", starts_q, exp_q);
        exp_q = '{32'd31};             chk_q("t2_done", dones_q, exp_q);

        // Abort while slot 1 of 3 waits: no done, idle.
        run_seq(3, 0, 2, 10, 17, -1, 25);
        exp_q = '{32'd1, 32'd13};      chk_q("t3_runs", runs_q, exp_q);
        exp_q = '{};                   chk_q("t3_done", dones_q, exp_q);
        chk("t3_busy_end", 32'(busy_o), 32'd0);

        // Stale done held high: restart at slot 0, ARM masks the done.
        run_seq(2, 0, 1, 0, -1, -1, 12);
        exp_q = '{32'd1, 32'd5};       chk_q("t4_runs", runs_q, exp_q);
        exp_q = '{32'd0, 32'd1};       chk_q("t4_slots", slots_q, exp_q);
        exp_q = '{32'd9};              chk_q("t4_done", dones_q, exp_q);

        // Length 7 clamps to 4 slots.
        run_seq(7, 0, 1, 0, -1, -1, 20);
        exp_q = '{32'd1, 32'd5, 32'd9, 32'd13};  chk_q("t5_runs", runs_q, exp_q);
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd3};   chk_q("t5_slots", slots_q, exp_q);
        exp_q = '{32'd17};             chk_q("t5_done", dones_q, exp_q);

        // Empty sequence: done without any run pulse.
        run_seq(0, 0, 0, 0, -1, -1, 4);
        exp_q = '{};                   chk_q("t6_runs", runs_q, exp_q);
        exp_q = '{32'd1};              chk_q("t6_done", dones_q, exp_q);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            rst         = ($urandom_range(0, 299) == 0);
            cfg_we_i    = ($urandom_range(0, 3) == 0);
            cfg_slot_i  = SLOT_W'($urandom_range(0, NUM_CFG - 1));
            cfg_field_i = 4'($urandom_range(0, 15));
            cfg_wdata_i = $urandom;
            go_i        = ($urandom_range(0, 7) == 0);
            seq_len_i   = (SLOT_W+1)'($urandom_range(0, 7));
            rep_cnt_i   = 16'($urandom_range(0, 2));
            abort_i     = ($urandom_range(0, 59) == 0);
            stall_i     = ($urandom_range(0, 1) == 1);
            gen_done_i  = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #2;
        rst = 1'b0; cfg_we_i = 1'b0; go_i = 1'b0; abort_i = 1'b0; gen_done_i = 1'b0;
        @(posedge clk); #7;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gen_sequencer.md
Name: gen_sequencer

Overview:
Scheduler for one Generator/AddressGen3 unit. It holds NUM_CFG complete address-pattern configurations in a local bank and, on go, runs slots 0..seq_len-1 back-to-back, repeating the whole sequence rep_cnt+1 times. It sits between the host config interface and the generator, drives the generator's run and running inputs, and consumes its done output.

Parameters:
PERIOD_W, 16, width of per/per2/per3/duty fields
DELAY_W, 7, width of delay field
NUM_CFG, 4, number of configuration slots (power of 2, >=2)
SLOT_W, $clog2(NUM_CFG), localparam, slot index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we_i  in  1  write strobe into config bank
cfg_slot_i  in  SLOT_W  slot written
cfg_field_i  in  4  field index (see Behaviour)
cfg_wdata_i  in  32  write data; narrow fields take LSBs
go_i  in  1  start sequence (single-cycle pulse)
abort_i  in  1  abandon sequence
seq_len_i  in  SLOT_W+1  slots per pass (clamped to NUM_CFG)
rep_cnt_i  in  16  extra passes (0 = run once)
stall_i  in  1  global datapath stall
gen_done_i  in  1  generator done (level)
gen_run_o  out  1  one-cycle run pulse to generator
gen_running_o  out  1  generator ready/running
gen_iter_o, gen_iter2_o, gen_iter3_o  out  3x32  loop iteration counts
gen_shift_o, gen_shift2_o, gen_shift3_o  out  3x32  loop shifts
gen_per_o, gen_per2_o, gen_per3_o  out  3xPERIOD_W  loop periods
gen_incr_o, gen_incr2_o, gen_incr3_o  out  3x32  loop increments
gen_duty_o  out  PERIOD_W  duty
gen_start_o  out  32  start address
gen_delay_o  out  DELAY_W  delay
busy_o  out  1  sequence active
done_o  out  1  one-cycle pulse at sequence completion
cur_slot_o  out  SLOT_W  slot currently loaded

Behaviour:
- Field map: 0 iter, 1 shift, 2 per, 3 incr, 4 iter2, 5 shift2, 6 per2, 7 incr2, 8 iter3, 9 shift3, 10 per3, 11 incr3, 12 duty, 13 start, 14 delay. Field 15 writes are ignored.
- Bank writes are accepted in every state. A write reaches the gen_* outputs only at the next LOAD of that slot.
- Reset: state IDLE; all outputs 0; slot and pass counters 0; bank contents cleared to 0.
- FSM: IDLE, LOAD, PULSE, ARM, WAIT, FINISH.
- IDLE:
  - go_i with eff_len = min(seq_len_i, NUM_CFG) != 0 -> LOAD; latch eff_len and rep_cnt_i; slot = 0, pass = 0.
  - go_i with eff_len == 0 -> FINISH; no run pulse.
- LOAD: copy bank[slot] into the gen_* output registers; cur_slot_o = slot; -> PULSE.
- PULSE: gen_run_o = 1 for exactly this cycle -> ARM.
- ARM: gen_done_i ignored, so stale done from the previous run is masked -> WAIT.
- WAIT, on gen_done_i = 1:
  - slot < eff_len-1: slot++ -> LOAD.
  - else pass < rep: pass++, slot = 0 -> LOAD.
  - else -> FINISH.
- FINISH: done_o = 1 for one cycle -> IDLE.
- Latency: go_i sampled at edge t -> LOAD in cycle t+1 -> gen_run_o high in cycle t+2. gen_done_i seen in WAIT -> next run pulse 2 cycles later.
- busy_o = (state != IDLE).
- gen_running_o = (state in PULSE, ARM, WAIT) & ~stall_i. Combinational on stall_i only; FSM transitions are unaffected by stall.
- go_i while busy: ignored.
- abort_i: highest priority, any state -> IDLE next cycle. No done_o pulse; gen_* outputs hold their last values. abort_i and go_i together in IDLE -> stay IDLE.
- rst mid-sequence: immediate return to reset values; bank cleared.
- Pass counter is 16-bit. rep_cnt_i = 0xFFFF gives 65536 passes, with no wrap before the compare.

Decomposition:
- Package gen_seq_pkg:
  - state enum.
  - FIELD_* index constants 0..14.
  - FIELD_W = 4.
- Sub-module gen_seq_cfg_bank: NUM_CFG x 15-field register file.
  - One write port (slot, field, data).
  - One full-slot combinational read port, indexed by slot.
- The top holds the FSM, counters and the output registers.

Test Plan:
- Single slot: write slot0 {iter=4, per=2, incr=1, start=0x100}, seq_len=1, rep=0, pulse go at t. Expect gen_run_o in cycle t+2 and gen_start_o=0x100 from t+2. Drive gen_done_i 10 cycles later; expect done_o exactly one cycle later, busy_o low after it.
- Three slots, rep=1: expect 6 run pulses with cur_slot_o sequence 0,1,2,0,1,2, each pulse 2 cycles after its gen_done_i, then one done_o.
- Stale done: hold gen_done_i=1 continuously before go. Expect the first run to complete only when done is seen in WAIT (one cycle after ARM), never in ARM.
- seq_len=0 -> done_o in cycle t+2, zero run pulses. seq_len=7 with NUM_CFG=4 -> exactly 4 slots run.
- abort_i in WAIT of slot 1 of 3 -> IDLE next cycle, no done_o. A second go restarts at slot 0.
- stall_i toggled during WAIT -> gen_running_o follows ~stall_i. Rewrite slot 2 start to 0x200 while slot 1 runs -> slot 2 LOAD outputs 0x200.
